// File: rtl/lvds_pattern_gen.sv
// lvds_pattern_gen
// Test-pattern source for the LVDS serializer transmit path. Every enabled
// clock it emits one parallel word of NR_CHAN x BITS_PER_CHAN bits. Each
// channel selects its own pattern: constant, framed A/B, alternating A/~A,
// counter, PRBS7 or walking-one.
//
// Ports
//   clk50       serializer parallel clock, rising edge
//   reset_n     asynchronous active-low reset
//   enable      advance one word per cycle while high
//   mode        per-channel mode, channel c at [3c+2:3c]
//   pattern_a   per-channel pattern A, channel c at [B*c+B-1:B*c]
//   pattern_b   per-channel pattern B, same layout
//   tx_data     registered word to the serializer, same layout
//   tx_valid    tx_data was updated on the last edge
//   frame_start tx_data holds word 0 of a frame
//
// Handshake: there is no ready. tx_valid is a one-cycle qualifier that is
// high exactly on cycles following an enabled edge. While enable is low,
// tx_data and frame_start hold their previous values and tx_valid is 0.
module lvds_pattern_gen #(
  parameter int NR_CHAN       = 4,
  parameter int BITS_PER_CHAN = 6,
  parameter int FRAME_LEN     = 2
) (
  input  logic                              clk50,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [3*NR_CHAN-1:0]              mode,
  input  logic [BITS_PER_CHAN*NR_CHAN-1:0]  pattern_a,
  input  logic [BITS_PER_CHAN*NR_CHAN-1:0]  pattern_b,
  output logic [BITS_PER_CHAN*NR_CHAN-1:0]  tx_data,
  output logic                              tx_valid,
  output logic                              frame_start
);

  localparam int B      = BITS_PER_CHAN;
  localparam int W      = BITS_PER_CHAN * NR_CHAN;
  localparam int WIDX_W = $clog2(FRAME_LEN);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(FRAME_LEN - 1);

  // Frame position and config shadow registers
  logic [WIDX_W-1:0]    widx;
  logic [3*NR_CHAN-1:0] mode_sh;
  logic [W-1:0]         pat_a_sh;
  logic [W-1:0]         pat_b_sh;

  // Generators. Every channel's generator advances identically on each
  // enabled edge from the same reset value, so a single copy serves them all.
  logic [B-1:0] cnt;
  logic [B-1:0] walk;
  logic [6:0]   lfsr;

  logic                 frame_first;
  logic [3*NR_CHAN-1:0] eff_mode;
  logic [W-1:0]         eff_a;
  logic [W-1:0]         eff_b;
  logic [W-1:0]         word_next;
  logic [B-1:0]         prbs_word;
  logic [6:0]           lfsr_next;
  logic [6:0]           lfsr_s;
  logic                 lfsr_fb;

  assign frame_first = (widx == '0);

  // On word 0 the live inputs are used directly: they are captured into the
  // shadows on the same edge, so the shadow copy is not valid until word 1.
  assign eff_mode = frame_first ? mode      : mode_sh;
  assign eff_a    = frame_first ? pattern_a : pat_a_sh;
  assign eff_b    = frame_first ? pattern_b : pat_b_sh;

  // PRBS7 runs BITS_PER_CHAN steps per word; word bit k is the feedback bit
  // produced by step k.
  always_comb begin
    lfsr_s    = lfsr;
    lfsr_fb   = 1'b0;
    prbs_word = '0;
    for (int k = 0; k < B; k++) begin
      lfsr_fb      = lfsr_s[6] ^ lfsr_s[5];
      prbs_word[k] = lfsr_fb;
      lfsr_s       = {lfsr_s[5:0], lfsr_fb};
    end
    lfsr_next = lfsr_s;
  end

  for (genvar c = 0; c < NR_CHAN; c++) begin : g_chan
    logic [2:0]   ch_mode;
    logic [B-1:0] ch_a;
    logic [B-1:0] ch_b;
    logic [B-1:0] ch_word;

    assign ch_mode = eff_mode[3*c +: 3];
    assign ch_a    = eff_a[B*c +: B];
    assign ch_b    = eff_b[B*c +: B];

    always_comb begin
      ch_word = '0;
      case (ch_mode)
        3'd0:    ch_word = ch_a;
        3'd1:    ch_word = frame_first ? ch_a : ch_b;
        3'd2:    ch_word = widx[0] ? ~ch_a : ch_a;
        3'd3:    ch_word = cnt;
        3'd4:    ch_word = prbs_word;
        3'd5:    ch_word = walk;
        default: ch_word = '0;
      endcase
    end

    assign word_next[B*c +: B] = ch_word;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      widx        <= '0;
      mode_sh     <= '0;
      pat_a_sh    <= '0;
      pat_b_sh    <= '0;
      cnt         <= '0;
      walk        <= B'(1);
      lfsr        <= 7'h7F;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      if (frame_first) begin
        mode_sh  <= mode;
        pat_a_sh <= pattern_a;
        pat_b_sh <= pattern_b;
      end
      widx        <= (widx == LAST_IDX) ? '0 : widx + 1'b1;
      cnt         <= cnt + 1'b1;
      walk        <= {walk[B-2:0], walk[B-1]};
      lfsr        <= lfsr_next;
      tx_data     <= word_next;
      tx_valid    <= 1'b1;
      frame_start <= frame_first;
    end else begin
      tx_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lvds_pattern_gen.sv
module tb_lvds_pattern_gen;

  localparam int B  = 6;
  localparam int NC = 4;
  localparam int W  = B * NC;
  localparam int EW = W + 1;   // {frame_start, tx_data}

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk50 = ~clk50;

  logic            enable = 1'b0;
  logic [3*NC-1:0] mode = '0;
  logic [W-1:0]    pattern_a = '0;
  logic [W-1:0]    pattern_b = '0;

  logic [W-1:0] tx_data2, tx_data4;
  logic         tx_valid2, tx_valid4;
  logic         fs2, fs4;

  lvds_pattern_gen #(.NR_CHAN(NC), .BITS_PER_CHAN(B), .FRAME_LEN(2)) dut2 (
    .clk50(clk50), .reset_n(reset_n), .enable(enable), .mode(mode),
    .pattern_a(pattern_a), .pattern_b(pattern_b),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .frame_start(fs2));

  lvds_pattern_gen #(.NR_CHAN(NC), .BITS_PER_CHAN(B), .FRAME_LEN(4)) dut4 (
    .clk50(clk50), .reset_n(reset_n), .enable(enable), .mode(mode),
    .pattern_a(pattern_a), .pattern_b(pattern_b),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .frame_start(fs4));

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q4[$];
  logic [EW-1:0] hold2, hold4;
  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: index 0 -> FRAME_LEN 2, index 1 -> FRAME_LEN 4
  int              m_widx[2];
  int              flen[2] = '{2, 4};
  logic [3*NC-1:0] sh_mode[2];
  logic [W-1:0]    sh_a[2];
  logic [W-1:0]    sh_b[2];
  logic [B-1:0]    m_cnt;
  logic [B-1:0]    m_walk;
  logic [6:0]      m_lfsr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_widx[i]  = 0;
      sh_mode[i] = '0;
      sh_a[i]    = '0;
      sh_b[i]    = '0;
    end
    m_cnt  = '0;
    m_walk = 6'b000001;
    m_lfsr = 7'h7F;
    exp_q2.delete();
    exp_q4.delete();
    hold2 = '0;
    hold4 = '0;
  endtask

  function automatic logic prbs_bit();
    logic fb;
    fb     = m_lfsr[6] ^ m_lfsr[5];
    m_lfsr = {m_lfsr[5:0], fb};
    return fb;
  endfunction

  // Called when an enabled edge is about to be driven: predicts the word.
  task automatic predict();
    logic [B-1:0] prbs;
    logic [W-1:0] word;
    logic [2:0]   md;
    logic [B-1:0] a, b, w;
    for (int k = 0; k < B; k++) prbs[k] = prbs_bit();
    for (int i = 0; i < 2; i++) begin
      if (m_widx[i] == 0) begin
        sh_mode[i] = mode;
        sh_a[i]    = pattern_a;
        sh_b[i]    = pattern_b;
      end
      word = '0;
      for (int c = 0; c < NC; c++) begin
        md = sh_mode[i][3*c +: 3];
        a  = sh_a[i][B*c +: B];
        b  = sh_b[i][B*c +: B];
        case (md)
          3'd0: w = a;
          3'd1: w = (m_widx[i] == 0) ? a : b;
          3'd2: w = (m_widx[i] % 2 == 1) ? ~a : a;
          3'd3: w = m_cnt;
          3'd4: w = prbs;
          3'd5: w = m_walk;
          default: w = '0;
        endcase
        word[B*c +: B] = w;
      end
      if (i == 0) exp_q2.push_back({m_widx[i] == 0, word});
      else        exp_q4.push_back({m_widx[i] == 0, word});
      m_widx[i] = (m_widx[i] + 1) % flen[i];
    end
    m_cnt  = m_cnt + 1'b1;
    m_walk = {m_walk[B-2:0], m_walk[B-1]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en);
    logic [EW-1:0] e;
    @(negedge clk50);
    enable = en;
    if (en) predict();
    @(posedge clk50);
    #1;
    check_eq("valid_fl2", {31'd0, tx_valid2}, {31'd0, en});
    check_eq("valid_fl4", {31'd0, tx_valid4}, {31'd0, en});
    if (exp_q2.size() > 0) begin
      e = exp_q2.pop_front();
      hold2 = e;
    end
    check_eq("data_fl2", 32'(tx_data2), 32'(hold2[W-1:0]));
    check_eq("fs_fl2", {31'd0, fs2}, {31'd0, hold2[W]});
    if (exp_q4.size() > 0) begin
      e = exp_q4.pop_front();
      hold4 = e;
    end
    check_eq("data_fl4", 32'(tx_data4), 32'(hold4[W-1:0]));
    check_eq("fs_fl4", {31'd0, fs4}, {31'd0, hold4[W]});
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_data2"}, 32'(tx_data2), 32'd0);
    check_eq({tag, "_valid2"}, {31'd0, tx_valid2}, 32'd0);
    check_eq({tag, "_fs2"}, {31'd0, fs2}, 32'd0);
    check_eq({tag, "_data4"}, 32'(tx_data4), 32'd0);
    check_eq({tag, "_valid4"}, {31'd0, tx_valid4}, 32'd0);
    check_eq({tag, "_fs4"}, {31'd0, fs4}, 32'd0);
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic apply_reset(input string tag);
    #3;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    model_reset();
    check_cleared(tag);
    @(posedge clk50);
    #1;
    check_cleared({tag, "_held"});
    @(negedge clk50);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge clk50);
    #1;
    check_cleared("por");
    apply_reset("rst0");

    // Framed / constant / counter mix
    mode      = {3'd3, 3'd1, 3'd0, 3'd1};
    pattern_a = {6'b000000, 6'b001000, 6'b101010, 6'b111100};
    pattern_b = '0;
    step(1'b1);
    check_eq("mix_word0_lit", 32'(tx_data2), 32'h008ABC);
    for (int i = 0; i < 66; i++) step(1'b1);

    // PRBS7 on all channels
    apply_reset("rst_prbs");
    mode = {NC{3'd4}};
    step(1'b1);
    check_eq("prbs_w0_lit", 32'(tx_data2), 32'h000000);
    step(1'b1);
    check_eq("prbs_w1_lit", 32'(tx_data2), 32'h041041);
    for (int i = 0; i < 10; i++) step(1'b1);

    // Walking one
    apply_reset("rst_walk");
    mode = {NC{3'd5}};
    for (int i = 0; i < 8; i++) step(1'b1);

    // Enable pulse 1,0,0,1 in counter mode
    apply_reset("rst_pulse");
    mode = {NC{3'd3}};
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check_eq("pulse_cnt1_lit", 32'(tx_data2), 32'h041041);

    // Mode switch mid-frame (word 2 of a 4-word frame)
    apply_reset("rst_switch");
    mode      = {3'd6, 3'd6, 3'd6, 3'd0};
    pattern_a = {18'd0, 6'b110011};
    step(1'b1);
    step(1'b1);
    mode = {3'd6, 3'd6, 3'd6, 3'd2};
    for (int i = 0; i < 6; i++) step(1'b1);
    check_eq("switch_last_lit", 32'(tx_data4), 32'h00000C);

    // Reset mid-frame with cnt = 5
    apply_reset("rst_pre_mid");
    mode = {NC{3'd3}};
    for (int i = 0; i < 5; i++) step(1'b1);
    apply_reset("rst_mid");
    step(1'b1);
    check_eq("post_rst_fs_lit", {31'd0, fs4}, 32'd1);
    step(1'b1);

    // Random configuration changes and enable gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < NC; c++) mode[3*c +: 3] = 3'($urandom_range(0, 7));
        pattern_a = W'($urandom);
        pattern_b = W'($urandom);
      end
      step($urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lvds_pattern_gen.md
# lvds_pattern_gen

Parametrised, per-channel-configurable test-pattern source for the LVDS serializer transmit path. It produces a parallel word of NR_CHAN × BITS_PER_CHAN bits every enabled clock. The word drives the serializer's tx_in directly, so deserializer alignment and bit ordering can be checked on the logic analyzer. It generalises the fixed clock/constant/sync/counter pattern to arbitrary channel count, word width and frame length, with runtime mode selection (constant, framed, alternating, counter, PRBS7, walking-one).

## Interface
- NR_CHAN, 4, number of LVDS data channels
- BITS_PER_CHAN, 6, serialization factor (bits per channel per word), 2..16
- FRAME_LEN, 2, words per frame, 2..256
- clk50  input  1  serializer parallel clock; all logic on rising edge
- reset_n  input  1  reset; asynchronous, active-low
- enable  input  1  advance generator by one word per cycle when high
- mode  input  3*NR_CHAN  per-channel mode, channel c at [3c+2:3c]
- pattern_a  input  BITS_PER_CHAN*NR_CHAN  per-channel pattern A
- pattern_b  input  BITS_PER_CHAN*NR_CHAN  per-channel pattern B
- tx_data  output  BITS_PER_CHAN*NR_CHAN  parallel word to serializer, channel c at [B*c+B-1:B*c]
- tx_valid  output  1  tx_data updated on the last edge
- frame_start  output  1  tx_data holds word 0 of a frame

## Operation
- Frame index widx counts 0..FRAME_LEN-1 and wraps to 0; advances only on enabled edges.
- Config latch: on an enabled edge with widx==0, mode, pattern_a and pattern_b are captured into shadow registers. Those values apply to word 0 and to all remaining words of that frame. Input changes mid-frame take effect at the next frame start only.
- Shared generators per channel advance on every enabled edge, regardless of the channel's mode:
  - cnt: BITS_PER_CHAN wide, reset 0; the word uses the current value, then cnt increments and wraps.
  - walk: one-hot, reset 1; the word uses the current value, then walk rotates left (MSB wraps to bit 0).
  - lfsr: 7 bit, reset 7'h7F. Per word it steps BITS_PER_CHAN times; each step computes n = s[6]^s[5], then s <= {s[5:0], n}. Word bit k is the n from step k.
- Mode per channel, using the latched values A/B:
  - 0: A on every word
  - 1: A when widx==0, B otherwise (frame clock / sync marker)
  - 2: A on even widx, ~A on odd widx
  - 3: cnt
  - 4: PRBS7 word
  - 5: walk
  - 6, 7: all zeros
- enable low: widx, generators, shadow registers and tx_data hold their values; tx_valid drops to 0.

## Timing
- Reset values: tx_data 0, tx_valid 0, frame_start 0, widx 0, cnt 0, walk 1, lfsr 7'h7F, shadow registers 0.
- Latency is one cycle. The word generated on an enabled edge n is on tx_data after edge n. tx_valid is 1 after edge n. frame_start is 1 after edge n exactly when that word had widx==0.
- First enabled edge after reset release always produces word 0 of a frame using the inputs sampled on that edge.
- frame_start holds its value while enable is low; tx_valid does not.
- reset_n asserted mid-frame: all state clears immediately, with no wait for a clock. The next frame restarts at widx 0.
- Simultaneous config change and frame start: the new inputs are captured and used for that word 0.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Test plan
- Default parameters, ch0 mode1 A=111100 B=000000, ch1 mode0 A=101010, ch2 mode1 A=001000 B=0, ch3 mode3, enable held high:
  - ch0 alternates 111100/000000.
  - ch1 is constant 101010.
  - ch2 alternates 001000/000000.
  - ch3 steps 0,1,2,…,63,0.
  - frame_start toggles 1,0,1,0.
- All channels mode4, enable high: each channel gives 000000 then 000001.
- All channels mode5: words 000001, 000010, 000100, …, 100000, 000001.
- enable pulse pattern 1,0,0,1 in mode3:
  - tx_data goes 0, holds 0 for two cycles, then 1.
  - tx_valid goes 1,0,0,1.
- FRAME_LEN=4, switch ch0 from mode0 to mode2 (A=110011) at widx 2: output holds 110011 until the next frame, then gives 110011, 001100, 110011, 001100.
- Assert reset_n mid-frame at widx 1 with cnt=5: outputs clear immediately. After release, the first word has cnt 0 and frame_start=1.
